fdct2d_8x8: RTL and testbench

//  Forward 8x8 2-D DCT; the encoder-side counterpart of the codebase's row/column IDCT top.

---
 rtl/fdct_pkg.sv | 70 +++++++
 rtl/fdct8.sv | 30 +++
 rtl/fdct2d_8x8.sv | 140 ++++++++++++++
 tb/tb_fdct2d_8x8.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdct_pkg.sv
// Shared widths, Q12 cosine constants and the rounding/saturation helpers for the 8x8 forward DCT.
// Row results carry ROW_FB fractional bits so that the two-stage rounding stays within 1 LSB.
package fdct_pkg;

    localparam int DW        = 17;
    localparam int COEF_FRAC = 12;
    localparam int IW        = DW + 4;
    localparam int ROW_FB    = IW - DW - 2;
    localparam int AW        = 48;

    localparam logic signed [AW-1:0] C1 = 48'sd4017;
    localparam logic signed [AW-1:0] C2 = 48'sd3784;
    localparam logic signed [AW-1:0] C3 = 48'sd3406;
    localparam logic signed [AW-1:0] C4 = 48'sd2896;
    localparam logic signed [AW-1:0] C5 = 48'sd2276;
    localparam logic signed [AW-1:0] C6 = 48'sd1567;
    localparam logic signed [AW-1:0] C7 = 48'sd799;

    typedef enum logic {RD_IDLE, RD_RUN} rd_state_t;

    // cos(k*pi/16) in Q1.COEF_FRAC for any non-negative k
    function automatic logic signed [AW-1:0] cos_q(input int k);
        int m;
        logic neg;
        logic signed [AW-1:0] v;
        m   = k % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       v = 48'sd4096;
            1:       v = C1;
            2:       v = C2;
            3:       v = C3;
            4:       v = C4;
            5:       v = C5;
            6:       v = C6;
            7:       v = C7;
            default: v = '0;
        endcase
        return neg ? -v : v;
    endfunction

    function automatic logic signed [AW-1:0] dct_coef(input int u, input int n);
        return (u == 0) ? C4 : cos_q((2 * n + 1) * u);
    endfunction

    function automatic logic signed [AW-1:0] rnd_shift(input logic signed [AW-1:0] a, input int sh);
        logic signed [AW-1:0] half;
        logic signed [AW-1:0] mag;
        half = 48'sd1 <<< (sh - 1);
        if (a >= 0) return (a + half) >>> sh;
        mag = -a;
        return -((mag + half) >>> sh);
    endfunction

    function automatic logic signed [AW-1:0] sat_w(input logic signed [AW-1:0] a, input int w);
        logic signed [AW-1:0] hi;
        logic signed [AW-1:0] lo;
        hi = (48'sd1 <<< (w - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (w - 1));
        if (a > hi) return hi;
        if (a < lo) return lo;
        return a;
    endfunction

endpackage

// File: rtl/fdct8.sv
// Combinational orthonormal 8-point DCT-II; full-precision products, round half away from zero.
// SHIFT folds the 1/2 scale, coefficient fraction and any fixed-point format change into one rounding step.
module fdct8
    import fdct_pkg::*;
#(
    parameter int IN_W  = DW,
    parameter int OUT_W = IW,
    parameter int SHIFT = COEF_FRAC + 1,
    parameter bit SAT   = 1'b0
) (
    input  logic [8*IN_W-1:0]  x,
    output logic [8*OUT_W-1:0] y
);

    logic signed [AW-1:0] acc [8];
    logic signed [AW-1:0] res [8];

    always_comb begin
        for (int u = 0; u < 8; u++) begin
            acc[u] = '0;
            for (int n = 0; n < 8; n++) begin
                acc[u] = acc[u] + AW'($signed(x[n*IN_W +: IN_W])) * dct_coef(u, n);
            end
            res[u] = rnd_shift(acc[u], SHIFT);
            if (SAT) res[u] = sat_w(res[u], OUT_W);
            y[u*OUT_W +: OUT_W] = OUT_W'(res[u]);
        end
    end

endmodule

// File: rtl/fdct2d_8x8.sv
// 8x8 forward 2-D DCT: row DCT into a ping-pong transpose buffer, column DCT out through one output register.
// Last row accepted at edge N gives the first beat after edge N+2; in_ready depends only on registered bank state.
module fdct2d_8x8
    import fdct_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [8*DW-1:0] din,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [8*DW-1:0] dout,
    output logic            out_last,
    output logic            busy
);

    rd_state_t       rd_state_q, rd_state_d;
    logic [2:0]      wr_row_q, wr_row_d;
    logic [2:0]      rd_col_q, rd_col_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [1:0]      bank_full_q, bank_full_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [8*DW-1:0] dout_q, dout_d;

    logic signed [IW-1:0] tbuf_q [2][8][8];

    logic [8*IW-1:0] row_res;
    logic [8*IW-1:0] col_in;
    logic [8*DW-1:0] col_res;
    logic            in_fire;

    fdct8 #(.IN_W(DW), .OUT_W(IW), .SHIFT(COEF_FRAC + 1 - ROW_FB), .SAT(1'b0)) u_row (
        .x (din),
        .y (row_res)
    );

    fdct8 #(.IN_W(IW), .OUT_W(DW), .SHIFT(COEF_FRAC + 1 + ROW_FB), .SAT(1'b1)) u_col (
        .x (col_in),
        .y (col_res)
    );

    assign in_ready  = !bank_full_q[wr_bank_q];
    assign in_fire   = in_valid && in_ready;
    assign busy      = (|bank_full_q) || (wr_row_q != 3'd0);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign dout      = dout_q;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            col_in[n*IW +: IW] = tbuf_q[rd_bank_q][n][rd_col_q];
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        wr_row_d    = wr_row_q;
        rd_col_d    = rd_col_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dout_d      = dout_q;

        if (in_fire) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
            end
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        // Writer only fills a non-full bank and the reader only drains a full one, so set and clear never collide.
        case (rd_state_q)
            RD_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    rd_state_d = RD_RUN;
                    rd_col_d   = 3'd0;
                end
            end
            RD_RUN: begin
                if (!out_valid_q || out_ready) begin
                    dout_d      = col_res;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_col_q == 3'd7);
                    rd_col_d    = rd_col_q + 3'd1;
                    if (rd_col_q == 3'd7) begin
                        bank_full_d[rd_bank_q] = 1'b0;
                        rd_bank_d              = ~rd_bank_q;
                        rd_state_d             = bank_full_d[~rd_bank_q] ? RD_RUN : RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q  <= RD_IDLE;
            wr_row_q    <= 3'd0;
            rd_col_q    <= 3'd0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            dout_q      <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            wr_row_q    <= wr_row_d;
            rd_col_q    <= rd_col_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            dout_q      <= dout_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int k = 0; k < 8; k++) begin
                tbuf_q[wr_bank_q][wr_row_q][k] <= row_res[k*IW +: IW];
            end
        end
    end

endmodule

// File: tb/tb_fdct2d_8x8.sv
// Bench for fdct2d_8x8: expected beats are queued at stimulus time and checked by an independent output monitor.
module tb_fdct2d_8x8;
    import fdct_pkg::*;

    localparam real PI = 3.14159265358979323846;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*DW-1:0] din = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [8*DW-1:0] dout;
    logic            out_last;
    logic            busy;

    fdct2d_8x8 dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    int    exp_v[$];
    int    exp_tol[$];
    bit    exp_last[$];
    string cur = "reset";
    bit    rand_rdy = 1'b0;
    bit    rdy_force = 1'b0;
    int    beats_seen = 0;
    int    blk [8][8];

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Output monitor: pops one expected beat per handshake and checks hold while stalled.
    logic [8*DW-1:0] prev_dout;
    bit              prev_last;
    bit              prev_stall = 1'b0;
    int              m_got, m_want, m_tol, m_bad, m_bad_got, m_bad_want;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!out_valid || dout !== prev_dout || out_last !== prev_last) begin
                    fails++;
                    $display("FAIL %s hold: valid=%0b last=%0b dout changed=%0b, required stable", cur, out_valid, out_last, dout !== prev_dout);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_last.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s: unexpected beat, none queued", cur);
                end else begin
                    tests++;
                    m_bad = -1;
                    m_tol = exp_tol.pop_front();
                    for (int u = 0; u < 8; u++) begin
                        m_want = exp_v.pop_front();
                        m_got  = int'($signed(dout[u*DW +: DW]));
                        if ((m_got - m_want > m_tol || m_want - m_got > m_tol) && m_bad < 0) begin
                            m_bad = u;
                            m_bad_got = m_got;
                            m_bad_want = m_want;
                        end
                    end
                    if (m_bad >= 0) begin
                        fails++;
                        $display("FAIL %s beat %0d coef F[%0d]: got %0d, expected %0d +/-%0d", cur, beats_seen, m_bad, m_bad_got, m_bad_want, m_tol);
                    end
                    check({cur, " out_last"}, int'(out_last), int'(exp_last.pop_front()));
                    beats_seen++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_last  = out_last;
        end
    end

    function automatic logic [8*DW-1:0] pack_row(input int r);
        logic [8*DW-1:0] p;
        for (int c = 0; c < 8; c++) p[c*DW +: DW] = DW'(blk[r][c]);
        return p;
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk[r][c] = v;
    endtask

    task automatic push_const(input int dc);
        for (int j = 0; j < 8; j++) begin
            for (int u = 0; u < 8; u++) exp_v.push_back((j == 0 && u == 0) ? dc : 0);
            exp_tol.push_back(0);
            exp_last.push_back(j == 7);
        end
    endtask

    // Floating-point orthonormal 2-D DCT of blk, rounded and saturated, 1 LSB tolerance.
    task automatic push_ref();
        real s, f, cu, cv;
        int  q;
        for (int v = 0; v < 8; v++) begin
            for (int u = 0; u < 8; u++) begin
                s = 0.0;
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        s += real'(blk[r][c]) * $cos(real'((2*r+1)*u) * PI / 16.0) * $cos(real'((2*c+1)*v) * PI / 16.0);
                cu = (u == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                cv = (v == 0) ? 1.0 / $sqrt(2.0) : 1.0;
                f  = cu * cv / 4.0 * s;
                q  = (f >= 0.0) ? $rtoi(f + 0.5) : -$rtoi(-f + 0.5);
                if (q > 65535) q = 65535;
                if (q < -65536) q = -65536;
                exp_v.push_back(q);
            end
            exp_tol.push_back(1);
            exp_last.push_back(v == 7);
        end
    endtask

    task automatic send_row(input logic [8*DW-1:0] r);
        int n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                check({cur, " in_ready timeout"}, 0, 1);
                return;
            end
        end
        din = r;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_block();
        for (int r = 0; r < 8; r++) send_row(pack_row(r));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_last.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({cur, " drain"}, exp_last.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " in_ready"}, int'(in_ready), 1);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out_last"}, int'(out_last), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " dout"}, int'(dout != '0), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;

        // Constant 16: DC 128, first beat two edges after the last row
        cur = "const16";
        rdy_force = 1'b1;
        fill(16);
        push_const(128);
        send_block();
        @(negedge clk);
        check("latency N+0 out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("latency N+1 out_valid", int'(out_valid), 0);
        @(negedge clk);
        check("latency N+2 out_valid", int'(out_valid), 1);
        drain();

        cur = "const-4";
        fill(-4);
        push_const(-32);
        send_block();
        drain();

        cur = "impulse";
        fill(0);
        blk[0][0] = 8;
        push_ref();
        send_block();
        drain();

        cur = "saturate";
        fill(65535);
        push_const(65535);
        send_block();
        fill(-65536);
        push_const(-65536);
        send_block();
        drain();

        // Both banks full with the output stalled
        cur = "backpressure";
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        fill(16);
        push_const(128);
        send_block();
        fill(-4);
        push_const(-32);
        send_block();
        @(negedge clk);
        check("in_ready after 16 rows", int'(in_ready), 0);
        check("busy after 16 rows", int'(busy), 1);
        fill(0);
        blk[0][0] = 8;
        push_ref();
        fork
            send_block();
            begin : watch
                bit found;
                int prev;
                found = 1'b0;
                repeat (3) @(negedge clk);
                rdy_force = 1'b1;
                prev = int'(in_ready);
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (out_valid && out_last) begin
                        check("in_ready with beat 7", int'(in_ready), 1);
                        check("in_ready before beat 7", prev, 0);
                        found = 1'b1;
                        break;
                    end
                    prev = int'(in_ready);
                end
                if (!found) check("beat 7 seen", 0, 1);
            end
        join
        drain();
        check("beats after backpressure", beats_seen, 64);

        cur = "random";
        rand_rdy = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) blk[r][c] = int'($urandom_range(0, 510)) - 255;
            push_ref();
            send_block();
        end
        drain();
        rand_rdy = 1'b0;

        // Reset with beat 3 pending and a partial block written
        cur = "reset_mid";
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        fill(16);
        push_const(128);
        send_block();
        begin : pass3
            int base;
            int n;
            base = beats_seen;
            n = 0;
            rdy_force = 1'b1;
            while (beats_seen < base + 3 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            rdy_force = 1'b0;
            check("beats before mid reset", beats_seen - base, 3);
        end
        fill(5);
        for (int r = 0; r < 6; r++) send_row(pack_row(r));
        @(posedge clk);
        #2;
        reset = 1'b1;
        exp_v.delete();
        exp_tol.delete();
        exp_last.delete();
        @(negedge clk);
        check_reset_outputs("mid reset");
        @(posedge clk);
        #1 reset = 1'b0;

        cur = "after_reset";
        rdy_force = 1'b1;
        fill(0);
        blk[0][0] = 8;
        blk[3][5] = -20;
        blk[7][7] = 13;
        push_ref();
        send_block();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
